// File: rtl/arm_fetch_stage.sv
// Instruction-fetch stage: owns the word-indexed PC, fills the IF/ID register from
// instruction memory, applies freezes and branch redirects, and keeps saturating event counters.
module arm_fetch_stage #(
  parameter int                          WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0]       RESET_PC   = '0,
  parameter int                          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze_i,
  input  logic                  branch_taken_i,
  input  logic [WORD_WIDTH-1:0] branch_addr_i,
  output logic [WORD_WIDTH-1:0] imem_addr_o,
  input  logic [WORD_WIDTH-1:0] imem_instruction_i,
  output logic [WORD_WIDTH-1:0] id_pc_o,
  output logic [WORD_WIDTH-1:0] id_instruction_o,
  output logic                  id_valid_o,
  output logic [CNT_WIDTH-1:0]  fetch_count_o,
  output logic [CNT_WIDTH-1:0]  stall_count_o,
  output logic [CNT_WIDTH-1:0]  flush_count_o,
  output logic                  state_o
);

  // Handshake: id_valid_o qualifies id_pc_o/id_instruction_o on every cycle. There is
  // no ready back-channel; freeze_i is the only way downstream can hold IF/ID, and
  // branch_taken_i overrides it by flushing IF/ID and reloading the PC.

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  localparam logic [WORD_WIDTH-1:0] PC_ONE  = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   pc_q, pc_d;
  logic [WORD_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [WORD_WIDTH-1:0]   id_instr_q, id_instr_d;
  logic [CNT_WIDTH-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]    flush_cnt_q, flush_cnt_d;
  logic                    do_fetch, do_stall, do_flush;
  logic [WORD_WIDTH-1:0]   pc_plus_one;

  assign pc_plus_one = pc_q + PC_ONE;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    do_fetch   = 1'b0;
    do_stall   = 1'b0;
    do_flush   = 1'b0;

    if (branch_taken_i) begin
      do_flush   = 1'b1;
      pc_d       = branch_addr_i;
      id_pc_d    = '0;
      id_instr_d = '0;
      state_d    = S_EMPTY;
    end else if (freeze_i) begin
      do_stall   = 1'b1;
    end else begin
      do_fetch   = 1'b1;
      pc_d       = pc_plus_one;
      id_pc_d    = pc_plus_one;
      id_instr_d = imem_instruction_i;
      state_d    = S_FULL;
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_fetch && fetch_cnt_q != CNT_MAX) fetch_cnt_d = fetch_cnt_q + CNT_ONE;
    if (do_stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (do_flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      pc_q        <= RESET_PC;
      id_pc_q     <= '0;
      id_instr_q  <= '0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr_o      = pc_q;
  assign id_pc_o          = id_pc_q;
  assign id_instruction_o = id_instr_q;
  assign id_valid_o       = (state_q == S_FULL);
  assign fetch_count_o    = fetch_cnt_q;
  assign stall_count_o    = stall_cnt_q;
  assign flush_count_o    = flush_cnt_q;
  assign state_o          = state_q;

endmodule
